// File: rtl/c_delay_pkg.sv
// Shared types and constants for the multi-channel power-sequencing delay.
// Latency: n/a (package only).
// Backpressure: n/a.
package c_delay_pkg;

    // Per-channel qualifier state; q is high in HIGH and FALL_WAIT.
    typedef enum logic [1:0] {
        LOW       = 2'd0,
        RISE_WAIT = 2'd1,
        HIGH      = 2'd2,
        FALL_WAIT = 2'd3
    } state_t;

    localparam int DEF_N        = 4;
    localparam int DEF_PRESCALE = 100;
    localparam int DEF_CW       = 16;
    localparam int DEF_TD_RISE  = 0;
    localparam int DEF_TD_FALL  = 30;

    // Width of the prescaler counter; clamped to 1 so degenerate values still elaborate.
    function automatic int prescale_w(input int prescale);
        return (prescale < 2) ? 1 : $clog2(prescale);
    endfunction

endpackage

// File: rtl/c_tick.sv
// Shared prescaler: one-cycle tick every PRESCALE clocks.
// Latency: first tick PRESCALE-1 cycles after reset release.
// Backpressure: none; free-running strobe.
module c_tick
    import c_delay_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int             PW   = prescale_w(PRESCALE);
    localparam logic [PW-1:0]  LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] cnt;

    // Count 0..PRESCALE-1 and wrap; held at zero in reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/c_delay_seq.sv
// N-channel rise/fall qualifying delay for power-good/enable levels, plus registered AND.
// Latency: 3 cycles with SYNC=1 and zero delay; (T-1)*PRESCALE+3..T*PRESCALE+3 otherwise.
// Backpressure: none; level inputs and level outputs.
module c_delay_seq
    import c_delay_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int PRESCALE = DEF_PRESCALE,
    parameter int CW       = DEF_CW,
    parameter int TD_RISE  = DEF_TD_RISE,
    parameter int TD_FALL  = DEF_TD_FALL,
    parameter int SYNC     = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] d,
    output logic [N-1:0] q,
    output logic [N-1:0] busy,
    output logic         pg_all,
    output logic         tick
);

    // Delays must fit in the counter so the terminal compare is reachable.
    if (((TD_RISE >> CW) != 0) || ((TD_FALL >> CW) != 0)) begin : g_bad_td
        $error("c_delay_seq: TD_RISE/TD_FALL must be < 2**CW");
    end

    localparam logic [CW-1:0] RISE_LAST = CW'(TD_RISE - 1);
    localparam logic [CW-1:0] FALL_LAST = CW'(TD_FALL - 1);

    logic [N-1:0] d_s;

    c_tick #(.PRESCALE(PRESCALE)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    if (SYNC != 0) begin : g_sync
        logic [N-1:0] s1;
        logic [N-1:0] s2;
        // Two-flop synchroniser for asynchronous raw levels.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                s1 <= '0;
                s2 <= '0;
            end else begin
                s1 <= d;
                s2 <= s1;
            end
        end
        assign d_s = s2;
    end else begin : g_nosync
        assign d_s = d;
    end

    for (genvar i = 0; i < N; i++) begin : g_ch
        state_t        st;
        state_t        st_nxt;
        logic [CW-1:0] cnt;
        logic [CW-1:0] cnt_nxt;
        logic          q_r;
        logic          busy_r;

        // Next state: an input change aborts a wait even when a tick lands in the same cycle.
        always_comb begin
            st_nxt  = st;
            cnt_nxt = cnt;
            case (st)
                LOW: begin
                    if (d_s[i]) begin
                        if (TD_RISE == 0) begin
                            st_nxt = HIGH;
                        end else begin
                            st_nxt  = RISE_WAIT;
                            cnt_nxt = '0;
                        end
                    end
                end
                RISE_WAIT: begin
                    if (!d_s[i]) begin
                        st_nxt  = LOW;
                        cnt_nxt = '0;
                    end else if (tick) begin
                        if (cnt == RISE_LAST) begin
                            st_nxt  = HIGH;
                            cnt_nxt = '0;
                        end else begin
                            cnt_nxt = cnt + CW'(1);
                        end
                    end
                end
                HIGH: begin
                    if (!d_s[i]) begin
                        if (TD_FALL == 0) begin
                            st_nxt = LOW;
                        end else begin
                            st_nxt  = FALL_WAIT;
                            cnt_nxt = '0;
                        end
                    end
                end
                FALL_WAIT: begin
                    if (d_s[i]) begin
                        st_nxt  = HIGH;
                        cnt_nxt = '0;
                    end else if (tick) begin
                        if (cnt == FALL_LAST) begin
                            st_nxt  = LOW;
                            cnt_nxt = '0;
                        end else begin
                            cnt_nxt = cnt + CW'(1);
                        end
                    end
                end
                default: begin
                    st_nxt  = LOW;
                    cnt_nxt = '0;
                end
            endcase
        end

        // State, counter and decoded outputs registered together so q/busy track the state edge.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                st     <= LOW;
                cnt    <= '0;
                q_r    <= 1'b0;
                busy_r <= 1'b0;
            end else begin
                st     <= st_nxt;
                cnt    <= cnt_nxt;
                q_r    <= (st_nxt == HIGH) || (st_nxt == FALL_WAIT);
                busy_r <= (st_nxt == RISE_WAIT) || (st_nxt == FALL_WAIT);
            end
        end

        assign q[i]    = q_r;
        assign busy[i] = busy_r;
    end

    // Aggregate power-good lags q by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pg_all <= 1'b0;
        end else begin
            pg_all <= &q;
        end
    end

endmodule

// File: tb/tb_c_delay_seq.sv
// Bench for c_delay_seq: scoreboard of expected q edges with spec latency windows.
// Latency: n/a.
// Backpressure: n/a.
module tb_c_delay_seq;

    localparam int N  = 2;
    localparam int P  = 4;
    localparam int CW = 4;
    localparam int TR = 2;
    localparam int TF = 3;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] d = '0;
    logic [N-1:0] q;
    logic [N-1:0] busy;
    logic         pg_all;
    logic         tick;

    always #5 clk = ~clk;

    c_delay_seq #(
        .N(N), .PRESCALE(P), .CW(CW), .TD_RISE(TR), .TD_FALL(TF), .SYNC(1)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .d      (d),
        .q      (q),
        .busy   (busy),
        .pg_all (pg_all),
        .tick   (tick)
    );

    typedef struct {
        int   ch;
        logic val;
        int   lo;
        int   hi;
    } exp_t;

    exp_t         sb[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           cyc = 0;
    logic [N-1:0] lev = '0;   // qualified level each channel is expected to settle at

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Drive one channel; a change that will be held long enough queues the q edge
    // with the window given by the delay rule (TD=0: 3 cycles; else (T-1)*P+3..T*P+3).
    task automatic set_d(input int ch, input logic v, input bit accept);
        exp_t e;
        int   t;
        d[ch] = v;
        if (v !== lev[ch] && accept) begin
            t     = v ? TR : TF;
            e.ch  = ch;
            e.val = v;
            e.lo  = cyc + ((t == 0) ? 3 : (t - 1) * P + 3);
            e.hi  = cyc + t * P + 3;
            sb.push_back(e);
            lev[ch] = v;
        end
    endtask

    // Monitor: samples 1 time unit after each rising edge.
    logic [N-1:0] prev_q = '0;
    bit           prev_rst = 1'b1;
    int           rel = 0;
    int           last_tick = -1;

    always begin
        @(posedge clk);
        #1;
        if (!rst_n) begin
            check("tick_in_reset", {31'd0, tick}, 32'd0);
            prev_rst = 1'b1;
        end else begin
            if (prev_rst) begin
                rel       = cyc - 1;
                last_tick = -1;
            end
            prev_rst = 1'b0;
            check("pg_all_follows_q", {31'd0, pg_all}, {31'd0, &prev_q});
            if (tick) begin
                if (last_tick < 0) check("tick_first", cyc, rel + P - 1);
                else               check("tick_period", cyc - last_tick, P);
                last_tick = cyc;
            end
            for (int ch = 0; ch < N; ch++) begin
                if (q[ch] !== prev_q[ch]) begin
                    int idx;
                    idx = -1;
                    foreach (sb[j]) if (idx < 0 && sb[j].ch == ch) idx = j;
                    if (idx < 0) begin
                        check($sformatf("q%0d_unexpected_edge", ch), {31'd0, q[ch]}, {31'd0, prev_q[ch]});
                    end else begin
                        exp_t e;
                        e = sb[idx];
                        sb.delete(idx);
                        check($sformatf("q%0d_value", ch), {31'd0, q[ch]}, {31'd0, e.val});
                        n_cmp++;
                        if (cyc < e.lo || cyc > e.hi) begin
                            n_err++;
                            $display("FAIL q%0d_timing: changed at cycle %0d, required %0d..%0d", ch, cyc, e.lo, e.hi);
                        end
                    end
                end
            end
        end
        prev_q = q;
    end

    // Random toggles on one channel: each change is held either long enough to be
    // guaranteed accepted (>= T*P+1) or short enough to be guaranteed rejected (<= (T-1)*P+1).
    task automatic run_chan(input int ch);
        for (int s = 0; s < 12; s++) begin
            logic v;
            int   t;
            int   len;
            bit   acc;
            v = ~d[ch];
            t = v ? TR : TF;
            if (v == lev[ch]) begin
                acc = 1'b0;
                len = $urandom_range(1, 12);
            end else begin
                acc = (t == 0) || ($urandom_range(0, 1) == 1);
                if (acc) len = $urandom_range(t * P + 1, t * P + 8);
                else     len = $urandom_range(1, (t - 1) * P + 1);
            end
            set_d(ch, v, acc);
            repeat (len) @(negedge clk);
        end
    endtask

    initial begin
        int k;
        int bc;
        int qlow;
        int qhi;

        // Reset held with inputs high: everything stays low.
        d = 2'b11;
        repeat (5) begin
            @(negedge clk);
            check("rst_q", {30'd0, q}, 32'd0);
            check("rst_busy", {30'd0, busy}, 32'd0);
            check("rst_pg_all", {31'd0, pg_all}, 32'd0);
            check("rst_tick", {31'd0, tick}, 32'd0);
        end
        d = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Channel 0 rises alone.
        set_d(0, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        check("busy0_before_wait", {31'd0, busy[0]}, 32'd0);
        @(negedge clk);
        check("busy0_at_cycle3", {31'd0, busy[0]}, 32'd1);
        repeat (12) @(negedge clk);
        check("q_ch0_only", {30'd0, q}, 32'd1);
        check("pg_all_ch0_only", {31'd0, pg_all}, 32'd0);

        // Channel 1 rises: pg_all one cycle after the later rise.
        set_d(1, 1'b1, 1'b1);
        for (k = 0; k < 20 && q !== 2'b11; k++) @(negedge clk);
        check("both_high", {30'd0, q}, 32'd3);
        check("pg_all_same_cycle", {31'd0, pg_all}, 32'd0);
        @(negedge clk);
        check("pg_all_next_cycle", {31'd0, pg_all}, 32'd1);

        // 5-cycle dropout on channel 0 is rejected.
        set_d(0, 1'b0, 1'b0);
        bc   = 0;
        qlow = 0;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (i == 5) set_d(0, 1'b1, 1'b0);
            bc   += int'(busy[0]);
            qlow += int'(!q[0]);
        end
        check("dropout_busy_cycles", bc, 5);
        check("dropout_q0_low_cycles", qlow, 0);

        // Sustained fall on channel 0, then channel 1.
        set_d(0, 1'b0, 1'b1);
        repeat (18) @(negedge clk);
        check("q_after_fall0", {30'd0, q}, 32'd2);
        check("pg_all_after_fall0", {31'd0, pg_all}, 32'd0);
        check("busy_idle", {30'd0, busy}, 32'd0);
        set_d(1, 1'b0, 1'b1);
        repeat (18) @(negedge clk);
        check("q_after_fall1", {30'd0, q}, 32'd0);

        // 6-cycle pulse on channel 1, phased so only one tick falls inside the wait.
        for (k = 0; k < 10 && tick !== 1'b1; k++) @(negedge clk);
        check("tick_seen", {31'd0, tick}, 32'd1);
        set_d(1, 1'b1, 1'b0);
        repeat (6) @(negedge clk);
        set_d(1, 1'b0, 1'b0);
        qhi = 0;
        bc  = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            qhi += int'(q[1]);
            bc  += int'(busy[1]);
        end
        check("short_rise_q1_high_cycles", qhi, 0);
        check("short_rise_busy1_seen", {31'd0, bc > 0}, 32'd1);

        // Reset in the middle of a fall wait.
        set_d(0, 1'b1, 1'b1);
        set_d(1, 1'b1, 1'b1);
        repeat (18) @(negedge clk);
        check("both_high_again", {30'd0, q}, 32'd3);
        set_d(0, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        check("midwait_busy0", {31'd0, busy[0]}, 32'd1);
        check("midwait_q0", {31'd0, q[0]}, 32'd1);
        rst_n = 1'b0;
        sb.delete();
        lev = '0;
        d   = '0;
        @(negedge clk);
        check("midwait_rst_q", {30'd0, q}, 32'd0);
        check("midwait_rst_busy", {30'd0, busy}, 32'd0);
        check("midwait_rst_pg_all", {31'd0, pg_all}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Independent random traffic on both channels.
        fork
            run_chan(0);
            run_chan(1);
        join
        repeat (25) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/c_delay_seq.md
Name: c_delay_seq

Overview:
Parametrised multi-channel power-sequencing delay: N independent channels, each with separate rise and fall delays.
- Each channel's output qualifies its input level, rejecting glitches shorter than the programmed delay.
- Sits between raw power-good/enable inputs and the sequencer logic; the aggregate pg_all feeds the PON state machine.
- All timing is in prescaled ticks derived from the system clock, not a free-running internal oscillator.

Parameters:
- N, 4, number of channels
- PRESCALE, 100, clk cycles per tick (>=2)
- CW, 16, delay counter width; TD_RISE and TD_FALL must be < 2**CW (elaboration-time check)
- TD_RISE, 0, ticks d must stay high before q rises; 0 = immediate
- TD_FALL, 30, ticks d must stay low before q falls; 0 = immediate
- SYNC, 1, 1 = 2-flop synchroniser on d; 0 = d used directly

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  synchronous reset, active-low
- d  input  N  raw per-channel level inputs
- q  output  N  delayed, qualified per-channel levels
- busy  output  N  per-channel timer running (RISE_WAIT or FALL_WAIT)
- pg_all  output  1  registered AND of all q bits
- tick  output  1  prescaler strobe, exposed for debug/verification

Behaviour:
- Reset (rst_n=0 at posedge): all channels LOW, cnt=0, q=0, busy=0, pg_all=0, sync flops=0, prescaler=0, tick=0. Reset mid-wait aborts the wait; q drops on the same edge.
- Prescaler (shared): counts 0..PRESCALE-1 from the first cycle after reset release, then wraps.
  - tick=1 in exactly the cycle where prescaler==PRESCALE-1.
  - First tick is PRESCALE-1 cycles after reset release, then every PRESCALE cycles.
- d_s = d delayed 2 cycles when SYNC=1; d_s = d when SYNC=0.
- Per-channel FSM (states LOW, RISE_WAIT, HIGH, FALL_WAIT); q=1 in HIGH and FALL_WAIT, q=0 otherwise; q is registered from the state.
- LOW:
  - d_s=1 and TD_RISE=0 -> HIGH.
  - d_s=1 and TD_RISE>0 -> RISE_WAIT, cnt=0.
- RISE_WAIT:
  - d_s=0 -> LOW (glitch rejected, cnt=0).
  - Otherwise, on tick: if cnt==TD_RISE-1 -> HIGH, else cnt++.
- HIGH:
  - d_s=0 and TD_FALL=0 -> LOW.
  - d_s=0 and TD_FALL>0 -> FALL_WAIT, cnt=0.
- FALL_WAIT:
  - d_s=1 -> HIGH (dropout rejected, cnt=0).
  - Otherwise, on tick: if cnt==TD_FALL-1 -> LOW, else cnt++.
- Simultaneous events: a d_s change wins over tick in the same cycle (abort beats expiry).
- Counter never wraps: it is bounded by TD-1 < 2**CW.
- Latency, SYNC=1, TD=0: q follows a d edge after 3 cycles.
- Latency, SYNC=1, TD=T>0: q changes between (T-1)*PRESCALE+3 and T*PRESCALE+3 cycles after the d edge. The exact value depends on prescaler phase.
- busy=1 exactly while in RISE_WAIT or FALL_WAIT, registered alongside q.
- pg_all registered one cycle after q: pg_all(t+1) = &q(t).
- Channels are fully independent; only the prescaler is shared.
- N=1, SYNC=0, TD_RISE=0 reproduces the legacy single-channel power-on hold: immediate rise, delayed fall.

Decomposition:
- Package c_delay_pkg:
  - state typedef (2 bits: LOW=0, RISE_WAIT=1, HIGH=2, FALL_WAIT=3)
  - function for prescaler width, $clog2(PRESCALE)
  - default delay constants
- Sub-module c_tick: prescaler with clk, rst_n, tick output and parameter PRESCALE. It is instantiated once.
- Channel FSMs are generated per channel inside c_delay_seq.

Test Plan (N=2, PRESCALE=4, TD_RISE=2, TD_FALL=3, SYNC=1, CW=4):
- Reset, then hold rst_n=0 for 5 cycles with d=2'b11 -> q=0, busy=0, pg_all=0, tick=0 throughout.
- Release reset, raise d[0] at cycle 0 and hold -> busy[0]=1 from cycle 3; q[0] rises within cycles 7..11; q[1]=0; pg_all stays 0.
- Raise d[1] as well, wait until both q=1 -> pg_all=1 exactly one cycle after the later q rise.
- With both q high, pulse d[0] low for 5 cycles -> FALL_WAIT entered then aborted; q[0] stays 1; busy[0] pulses for 5 cycles.
- With both q high, drop d[0] and hold low -> q[0] falls within cycles 11..15 of the edge; pg_all falls one cycle later.
- Raise d[1] at cycle 0, then drop it at cycle 6 (before expiry) -> q[1] never rises. Assert rst_n=0 mid-FALL_WAIT -> q=0 on the next edge.
